// File: rtl/drive_state_keeper_pkg.sv
//------------------------------------------------------------------------------
// drive_pkg : shared run/moving state encodings and power levels
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package drive_pkg;

    typedef enum logic [1:0] {
        NSTART = 2'b00,
        START  = 2'b01,
        MOVING = 2'b10
    } run_state_e;

    localparam logic [3:0] NON_MOVING   = 4'b0000;
    localparam logic [3:0] MOVE_FORWARD = 4'b0001;
    localparam logic [3:0] MOVE_BACK    = 4'b0010;
    localparam logic [3:0] TURN_LEFT    = 4'b0100;
    localparam logic [3:0] TURN_RIGHT   = 4'b1000;

    localparam logic POFF = 1'b0;
    localparam logic PON  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/drive_state_keeper_if.sv
//------------------------------------------------------------------------------
// drive_state_keeper_if : controller <-> state keeper signal bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface drive_state_keeper_if;
    logic        power_on_btn;
    logic        power_off_btn;
    logic        activity;
    logic        manual_power;
    logic [1:0]  next_state;
    logic [3:0]  next_moving_state;
    logic        turn_left_req;
    logic        turn_right_req;
    logic        power;
    logic [1:0]  state;
    logic [3:0]  moving_state;
    logic        turn_left_light;
    logic        turn_right_light;
    logic [13:0] mileage;

    modport master (
        output power_on_btn, power_off_btn, activity, manual_power,
               next_state, next_moving_state, turn_left_req, turn_right_req,
        input  power, state, moving_state, turn_left_light, turn_right_light, mileage
    );

    modport slave (
        input  power_on_btn, power_off_btn, activity, manual_power,
               next_state, next_moving_state, turn_left_req, turn_right_req,
        output power, state, moving_state, turn_left_light, turn_right_light, mileage
    );
endinterface

`default_nettype wire

// File: rtl/turn_blinker.sv
//------------------------------------------------------------------------------
// turn_blinker : one turn light, lit on request rise, toggles every HALF cycles
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module turn_blinker #(
    parameter int HALF = 50_000_000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    input  wire logic req,
    output logic      light
);
    localparam int            PHASE_W    = $clog2(HALF + 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(HALF - 1);

    logic               req_q;
    logic               light_q;
    logic [PHASE_W-1:0] phase_q;

    always_ff @(posedge clk) begin
        if (rst || !(en && req)) begin
            req_q   <= 1'b0;
            light_q <= 1'b0;
            phase_q <= '0;
        end else if (!req_q) begin
            req_q   <= 1'b1;
            light_q <= 1'b1;
            phase_q <= '0;
        end else if (phase_q == PHASE_LAST) begin
            light_q <= ~light_q;
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + 1'b1;
        end
    end

    assign light = light_q;

endmodule

`default_nettype wire

// File: rtl/drive_state_keeper.sv
//------------------------------------------------------------------------------
// drive_state_keeper : power/run/moving state registers, idle off, odometer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module drive_state_keeper
    import drive_pkg::*;
#(
    parameter int PRESS_CYCLES = 100_000_000,
    parameter int IDLE_CYCLES  = 1_000_000_000,
    parameter int BLINK_HALF   = 50_000_000,
    parameter int MILE_CYCLES  = 100_000_000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    drive_state_keeper_if.slave bus
);
    localparam int PRESS_W = $clog2(PRESS_CYCLES + 1);
    localparam int IDLE_W  = $clog2(IDLE_CYCLES + 1);
    localparam int MILE_W  = $clog2(MILE_CYCLES + 1);

    localparam logic [PRESS_W-1:0] PRESS_LAST = PRESS_W'(PRESS_CYCLES - 1);
    localparam logic [PRESS_W-1:0] PRESS_MAX  = PRESS_W'(PRESS_CYCLES);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [MILE_W-1:0]  MILE_LAST  = MILE_W'(MILE_CYCLES - 1);
    localparam logic [13:0]        MILE_TOP   = 14'd9999;

    logic               power_q;
    run_state_e         state_q;
    logic [3:0]         moving_q;
    logic [PRESS_W-1:0] press_cnt_q;
    logic [IDLE_W-1:0]  idle_cnt_q;
    logic [MILE_W-1:0]  mile_cnt_q;
    logic [13:0]        mileage_q;

    logic press_done;
    logic idle_timeout;
    logic power_drop;

    assign press_done   = (power_q == POFF) && bus.power_on_btn && !bus.power_off_btn
                          && (press_cnt_q == PRESS_LAST);
    assign idle_timeout = (state_q != MOVING) && !bus.activity && (idle_cnt_q == IDLE_LAST);
    assign power_drop   = bus.power_off_btn || !bus.manual_power || idle_timeout;

    // Saturates while held so a long press powers on only once; off button wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_cnt_q <= '0;
        end else if (bus.power_on_btn && !bus.power_off_btn) begin
            if (press_cnt_q != PRESS_MAX) begin
                press_cnt_q <= press_cnt_q + 1'b1;
            end
        end else begin
            press_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            power_q    <= POFF;
            state_q    <= NSTART;
            moving_q   <= NON_MOVING;
            idle_cnt_q <= '0;
        end else if (power_q == POFF || power_drop) begin
            power_q    <= (power_q == POFF && press_done) ? PON : POFF;
            state_q    <= NSTART;
            moving_q   <= NON_MOVING;
            idle_cnt_q <= '0;
        end else begin
            case (bus.next_state)
                NSTART, START, MOVING: begin
                    state_q  <= run_state_e'(bus.next_state);
                    moving_q <= bus.next_moving_state;
                end
                default: begin
                    state_q  <= NSTART;
                    moving_q <= NON_MOVING;
                end
            endcase
            if (bus.activity || state_q == MOVING) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
        end
    end

    // mileage survives power-off; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mile_cnt_q <= '0;
            mileage_q  <= '0;
        end else if (state_q != MOVING) begin
            mile_cnt_q <= '0;
        end else if (moving_q != NON_MOVING) begin
            if (mile_cnt_q == MILE_LAST) begin
                mile_cnt_q <= '0;
                mileage_q  <= (mileage_q == MILE_TOP) ? 14'd0 : mileage_q + 14'd1;
            end else begin
                mile_cnt_q <= mile_cnt_q + 1'b1;
            end
        end
    end

    turn_blinker #(.HALF(BLINK_HALF)) u_left_blinker (
        .clk   (clk),
        .rst   (rst),
        .en    (power_q),
        .req   (bus.turn_left_req),
        .light (bus.turn_left_light)
    );

    turn_blinker #(.HALF(BLINK_HALF)) u_right_blinker (
        .clk   (clk),
        .rst   (rst),
        .en    (power_q),
        .req   (bus.turn_right_req),
        .light (bus.turn_right_light)
    );

    assign bus.power        = power_q;
    assign bus.state        = state_q;
    assign bus.moving_state = moving_q;
    assign bus.mileage      = mileage_q;

endmodule

`default_nettype wire

// File: tb/tb_drive_state_keeper.sv
//------------------------------------------------------------------------------
// tb_drive_state_keeper : directed vectors and sequences for drive_state_keeper
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_drive_state_keeper;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    drive_state_keeper_if bus();

    drive_state_keeper #(
        .PRESS_CYCLES (4),
        .IDLE_CYCLES  (8),
        .BLINK_HALF   (2),
        .MILE_CYCLES  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  ns;
        logic [3:0]  nms;
        logic        mp;
        logic        exp_p;
        logic [1:0]  exp_s;
        logic [3:0]  exp_m;
        logic [13:0] exp_mil;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic power_up();
        bus.power_on_btn = 1'b1;
        tick(4);
        bus.power_on_btn = 1'b0;
        check("power_up", 32'(bus.power), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] blink_pat;
        blink_pat = 7'b0110011;   // bit i = expected light after tick i+1

        vecs[0] = '{2'b01, 4'b0000, 1'b1, 1'b1, 2'b01, 4'b0000, 14'd0};
        vecs[1] = '{2'b10, 4'b0001, 1'b1, 1'b1, 2'b10, 4'b0001, 14'd0};
        vecs[2] = '{2'b10, 4'b0010, 1'b1, 1'b1, 2'b10, 4'b0010, 14'd0};
        vecs[3] = '{2'b10, 4'b1000, 1'b1, 1'b1, 2'b10, 4'b1000, 14'd0};
        vecs[4] = '{2'b11, 4'b0100, 1'b1, 1'b1, 2'b00, 4'b0000, 14'd1};
        vecs[5] = '{2'b01, 4'b0000, 1'b1, 1'b1, 2'b01, 4'b0000, 14'd1};
        vecs[6] = '{2'b10, 4'b0100, 1'b1, 1'b1, 2'b10, 4'b0100, 14'd1};
        vecs[7] = '{2'b10, 4'b0000, 1'b0, 1'b0, 2'b00, 4'b0000, 14'd1};

        rst                   = 1'b1;
        bus.power_on_btn      = 1'b0;
        bus.power_off_btn     = 1'b0;
        bus.activity          = 1'b0;
        bus.manual_power      = 1'b1;
        bus.next_state        = 2'b00;
        bus.next_moving_state = 4'b0000;
        bus.turn_left_req     = 1'b0;
        bus.turn_right_req    = 1'b0;
        tick(2);
        check("reset_power",   32'(bus.power), 0);
        check("reset_state",   32'(bus.state), 0);
        check("reset_moving",  32'(bus.moving_state), 0);
        check("reset_left",    32'(bus.turn_left_light), 0);
        check("reset_right",   32'(bus.turn_right_light), 0);
        check("reset_mileage", 32'(bus.mileage), 0);
        rst = 1'b0;
        tick(1);

        // Short press must not power on; a full press does, on its 4th edge.
        bus.power_on_btn = 1'b1;
        tick(3);
        check("short_press_power", 32'(bus.power), 0);
        bus.power_on_btn = 1'b0;
        tick(1);
        bus.power_on_btn = 1'b1;
        tick(3);
        check("press3_power", 32'(bus.power), 0);
        tick(1);
        check("press4_power", 32'(bus.power), 1);
        check("press4_state", 32'(bus.state), 0);
        bus.power_on_btn = 1'b0;

        bus.activity = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.next_state        = vecs[i].ns;
            bus.next_moving_state = vecs[i].nms;
            bus.manual_power      = vecs[i].mp;
            tick(1);
            check($sformatf("vec%0d_power", i),   32'(bus.power),        32'(vecs[i].exp_p));
            check($sformatf("vec%0d_state", i),   32'(bus.state),        32'(vecs[i].exp_s));
            check($sformatf("vec%0d_moving", i),  32'(bus.moving_state), 32'(vecs[i].exp_m));
            check($sformatf("vec%0d_mileage", i), 32'(bus.mileage),      32'(vecs[i].exp_mil));
        end
        bus.manual_power = 1'b1;
        tick(2);
        check("mileage_kept_off", 32'(bus.mileage), 1);

        // Idle timeout without activity
        bus.next_state        = 2'b01;
        bus.next_moving_state = 4'b0000;
        power_up();
        tick(1);
        bus.activity = 1'b0;
        tick(7);
        check("idle7_power", 32'(bus.power), 1);
        tick(1);
        check("idle8_power", 32'(bus.power), 0);
        check("idle8_state", 32'(bus.state), 0);

        // Activity at cycle 6 restarts the idle window
        power_up();
        bus.activity = 1'b1;
        tick(1);
        bus.activity = 1'b0;
        tick(5);
        bus.activity = 1'b1;
        tick(1);
        bus.activity = 1'b0;
        tick(3);
        check("idle_act_cycle9", 32'(bus.power), 1);
        tick(4);
        check("idle_act_7after", 32'(bus.power), 1);
        tick(1);
        check("idle_act_8after", 32'(bus.power), 0);

        // Left blink, then both sides in phase, then power-off blanking
        power_up();
        bus.activity      = 1'b1;
        bus.turn_left_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check($sformatf("left_blink%0d", i), 32'(bus.turn_left_light), 32'(blink_pat[i]));
            check($sformatf("right_idle%0d", i), 32'(bus.turn_right_light), 0);
        end
        bus.turn_left_req = 1'b0;
        tick(1);
        check("left_drop", 32'(bus.turn_left_light), 0);
        bus.turn_left_req  = 1'b1;
        bus.turn_right_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("both_left%0d", i),  32'(bus.turn_left_light),  32'(blink_pat[i]));
            check($sformatf("both_right%0d", i), 32'(bus.turn_right_light), 32'(blink_pat[i]));
        end
        bus.power_off_btn = 1'b1;
        tick(1);
        check("blink_off_power", 32'(bus.power), 0);
        bus.power_off_btn = 1'b0;
        tick(1);
        check("blink_off_left",  32'(bus.turn_left_light), 0);
        check("blink_off_right", 32'(bus.turn_right_light), 0);
        bus.turn_left_req  = 1'b0;
        bus.turn_right_req = 1'b0;

        // Odometer: from mileage 1 to 9999, wrap to 0, then mid-count exit clears mile_cnt
        bus.next_state        = 2'b10;
        bus.next_moving_state = 4'b0100;
        power_up();
        tick(1);
        check("odo_state", 32'(bus.state), 2);
        tick(29994);
        check("odo_9999", 32'(bus.mileage), 9999);
        tick(2);
        check("odo_9999_hold", 32'(bus.mileage), 9999);
        tick(1);
        check("odo_wrap", 32'(bus.mileage), 0);
        tick(1);
        bus.next_state = 2'b01;
        tick(1);
        check("odo_exit_state",   32'(bus.state), 1);
        check("odo_exit_mileage", 32'(bus.mileage), 0);
        tick(1);
        bus.next_state = 2'b10;
        tick(1);
        tick(2);
        check("odo_reentry2", 32'(bus.mileage), 0);
        tick(1);
        check("odo_reentry3", 32'(bus.mileage), 1);

        // Both buttons at power=1: off wins, held pair never re-powers
        bus.turn_left_req = 1'b1;
        tick(1);
        bus.power_on_btn  = 1'b1;
        bus.power_off_btn = 1'b1;
        tick(1);
        check("both_btn_power", 32'(bus.power), 0);
        check("both_btn_state", 32'(bus.state), 0);
        tick(5);
        check("both_btn_hold", 32'(bus.power), 0);
        bus.power_on_btn  = 1'b0;
        bus.power_off_btn = 1'b0;
        tick(1);

        // Reset while MOVING, blinking and mid-press
        power_up();
        tick(1);
        bus.power_on_btn = 1'b1;
        tick(1);
        check("pre_rst_state",   32'(bus.state), 2);
        check("pre_rst_left",    32'(bus.turn_left_light), 1);
        check("pre_rst_mileage", 32'(bus.mileage), 1);
        rst = 1'b1;
        tick(1);
        check("rst_power",   32'(bus.power), 0);
        check("rst_state",   32'(bus.state), 0);
        check("rst_moving",  32'(bus.moving_state), 0);
        check("rst_left",    32'(bus.turn_left_light), 0);
        check("rst_right",   32'(bus.turn_right_light), 0);
        check("rst_mileage", 32'(bus.mileage), 0);
        bus.power_on_btn  = 1'b0;
        bus.turn_left_req = 1'b0;
        rst = 1'b0;
        tick(2);
        check("post_rst_power", 32'(bus.power), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/drive_state_keeper.md
Name: drive_state_keeper

Overview:
Sequential back end of the manual driving controller. It holds the car's power, run state and moving state, and feeds `power`, `state` and `moving_state` back to the combinational controller, which returns `next_state`, `next_moving_state` and `manual_power`. It also handles the power-button press timing, idle auto-power-off, turn-light blinking and the mileage odometer that drives the display.

Parameters:
- PRESS_CYCLES, 100_000_000: power-on button must be held this many consecutive cycles (1 s at 100 MHz).
- IDLE_CYCLES, 1_000_000_000: cycles without activity in NSTART/START before auto power-off.
- BLINK_HALF, 50_000_000: half-period of the turn-light blink, in cycles.
- MILE_CYCLES, 100_000_000: cycles of motion per mileage increment.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- power_on_btn  in  1  power-on push button, already debounced
- power_off_btn  in  1  power-off push button, already debounced
- activity  in  1  one-cycle pulse on any driver input change (clutch, brake, throttle, rgs, left, right)
- manual_power  in  1  controller power request; 0 = stall
- next_state  in  2  controller next run state
- next_moving_state  in  4  controller next moving state
- turn_left_req  in  1  controller left-light request
- turn_right_req  in  1  controller right-light request
- power  out  1  registered power status
- state  out  2  registered run state: NSTART=00, START=01, MOVING=10
- moving_state  out  4  registered moving state: NON_MOVING=0000, FWD=0001, BACK=0010, LEFT=0100, RIGHT=1000
- turn_left_light  out  1  blinked left light
- turn_right_light  out  1  blinked right light
- mileage  out  14  odometer, 0..9999

Behaviour:
- Reset: power=0, state=NSTART, moving_state=0000, both lights 0, mileage=0, all internal counters 0.
- Power off (power=0):
  - press_cnt increments while power_on_btn=1; it clears when the button is released.
  - power_on_btn held for PRESS_CYCLES consecutive cycles → power=1 at the following edge. state stays NSTART.
  - press_cnt saturates; a held button does nothing further.
- Power on (power=1), one priority per cycle, highest first:
  1. power_off_btn=1 → power=0.
  2. manual_power=0 → power=0 (stall).
  3. Idle timeout → power=0.
  4. Otherwise state<=next_state and moving_state<=next_moving_state. Latency is 1 cycle.
- Any transition to power=0 forces state=NSTART and moving_state=0000 on the same edge.
- power_on_btn is ignored while power=1.
- Simultaneous power_on_btn and power_off_btn: off wins, and press_cnt clears.
- Idle timer:
  - Counts only when power=1 and state≠MOVING.
  - Clears on activity=1, on entering MOVING, and on power-off.
  - Timeout when it reaches IDLE_CYCLES-1 with no activity that cycle.
  - Activity on the timeout cycle cancels the timeout.
- Blinker, one per side:
  - Request low → light 0 and phase counter 0.
  - On a request rising edge the light is 1 on the next cycle.
  - Light toggles every BLINK_HALF cycles while the request stays high.
  - Both requests high → both sides blink independently, in phase if they rose together.
  - power=0 → lights 0.
- Odometer:
  - mile_cnt advances while state=MOVING and moving_state≠0000.
  - At MILE_CYCLES-1, mile_cnt wraps to 0 and mileage increments; 9999 wraps to 0.
  - Leaving MOVING clears mile_cnt; mileage holds.
  - mileage is retained across power-off and cleared only by rst.
- Illegal next_state=11 is registered as NSTART with moving_state=0000.
- rst mid-operation (MOVING, blinking, mid-press) returns every output to its reset value on that edge.

Decomposition:
- Package `drive_pkg` holds:
  - run-state constants NSTART, START, MOVING;
  - moving-state constants NON_MOVING, MOVE_FORWARD, MOVE_BACK, TURN_LEFT, TURN_RIGHT;
  - POFF and PON.
- Sub-module `turn_blinker` (parameter HALF; ports clk, rst, en, req, light), instantiated once per side with en=power.

Test Plan (PRESS_CYCLES=4, IDLE_CYCLES=8, BLINK_HALF=2, MILE_CYCLES=3):
1. Power-on press: hold power_on_btn 3 cycles, release, then hold 4 cycles → power stays 0 after the 3-cycle press and becomes 1 at the edge after the 4th cycle; state=00.
2. Run-state tracking and stall: power=1, next_state=01 → state=01 one cycle later. Then next_state=10, next_moving_state=0001 → state=10, moving_state=0001. Then manual_power=0 → power=0, state=00, moving_state=0000 on the next edge.
3. Idle power-off: power=1, state=01, no activity → power=0 after 8 cycles. Repeat with an activity pulse at cycle 6 → still on at cycle 9; off 8 cycles after the pulse.
4. Left blink: hold turn_left_req high → left light pattern 1,1,0,0,1,1,… with turn_right_light=0. Drop the request → light 0 on the next cycle.
5. Odometer wrap: preload via 29,997 moving cycles, or force mileage=9999 in the bench; hold state=10, moving_state=0100 for 3 cycles → mileage=0. Switch to state=01 mid-count → mileage holds and mile_cnt clears.
6. Conflicting buttons and reset: power_on_btn and power_off_btn both high at power=1 → power=0. Assert rst while MOVING and blinking → all outputs at reset values on the next edge.
